// File: rtl/ace_snapshot_loader_pkg.sv
// rtl/ace_snapshot_loader_pkg.sv - shared types and constants for the snapshot loader
package ace_snapshot_loader_pkg;

    // Escape byte that introduces a run or the end-of-stream marker in RLE mode.
    localparam logic [7:0] ACE_ESC = 8'hED;

    // Default address of the first byte written into target memory.
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h2000;

    // Decoder states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LIT,
        ST_ESC,
        ST_CNT,
        ST_RUN,
        ST_DONE,
        ST_HOLD
    } loader_state_e;

endpackage

// File: rtl/ace_snapshot_loader_fifo.sv
// rtl/ace_snapshot_loader_fifo.sv - input byte FIFO with flush and show-ahead output
module loader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // A flush empties the FIFO but still captures a byte arriving in the same cycle.
    assign wr_en   = flush_i ? push_i : do_push;
    assign wr_idx  = flush_i ? '0 : wr_ptr_q;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push_i ? AW'(1) : '0;
            count_q  <= push_i ? (AW+1)'(1) : '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_idx] <= din_i;
    end

endmodule

// File: rtl/ace_snapshot_loader.sv
// rtl/ace_snapshot_loader.sv - streams a raw or RLE snapshot into target memory
module ace_snapshot_loader
    import ace_snapshot_loader_pkg::*;
#(
    parameter int                 ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                 FIFO_DEPTH  = 8,
    parameter int                 HOLD_CYCLES = 16,
    parameter bit                 RLE_EN      = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    input  logic              rle_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    input  logic              mem_ready,
    output logic              loader_reset,
    output logic              busy,
    output logic              overflow,
    output logic [ADDR_W-1:0] bytes_written
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    loader_state_e      state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  bw_q, bw_d;
    logic               ovf_q, ovf_d;
    logic               rle_q, rle_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         val_q, val_d;
    logic [15:0]        hold_q, hold_d;
    logic               dl_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_flush;
    logic [7:0]         fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic               dl_rise;
    logic               stream_end;

    assign fifo_push  = ioctl_wr && ioctl_download;
    assign dl_rise    = ioctl_download && !dl_q;
    assign stream_end = !ioctl_download && (fifo_level == '0);

    loader_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .din_i   (ioctl_dout),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // State and datapath registers; reset aborts any load in progress at once.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            wr_q    <= 1'b0;
            bw_q    <= '0;
            ovf_q   <= 1'b0;
            rle_q   <= 1'b0;
            cnt_q   <= '0;
            val_q   <= '0;
            hold_q  <= '0;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            bw_q    <= bw_d;
            ovf_q   <= ovf_d;
            rle_q   <= rle_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            hold_q  <= hold_d;
            dl_q    <= ioctl_download;
        end
    end

    // Decoder next state, write handshake and FIFO pop control.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q;
        bw_d       = bw_q;
        ovf_d      = ovf_q;
        rle_d      = rle_q;
        cnt_d      = cnt_q;
        val_d      = val_q;
        hold_d     = hold_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        // Retire the pending write; the slot is then free to be reloaded below.
        if (wr_q && mem_ready) begin
            wr_d   = 1'b0;
            addr_d = addr_q + ADDR_W'(1);
            bw_d   = bw_q + ADDR_W'(1);
        end

        // A new write is only loaded on a cycle the memory is ready, so a
        // stalled memory leaves bytes queued in the FIFO instead of the slot.
        case (state_q)
            ST_LIT: begin
                if (!fifo_empty) begin
                    if (rle_q && fifo_dout == ACE_ESC) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_ESC;
                    end else if (mem_ready) begin
                        fifo_pop = 1'b1;
                        wr_d     = 1'b1;
                        data_d   = fifo_dout;
                    end
                end else if (stream_end && !wr_q) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            ST_ESC: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_dout == 8'h00) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = fifo_dout;
                        state_d = ST_CNT;
                    end
                end else if (stream_end) begin
                    state_d = ST_LIT;
                end
            end
            ST_CNT: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    val_d    = fifo_dout;
                    state_d  = ST_RUN;
                end else if (stream_end) begin
                    state_d = ST_LIT;
                end
            end
            ST_RUN: begin
                if (mem_ready) begin
                    wr_d   = 1'b1;
                    data_d = val_q;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = ST_LIT;
                end
            end
            ST_DONE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                end else if (stream_end && !wr_q) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            ST_HOLD: begin
                if (int'(hold_q) + 1 >= HOLD_CYCLES) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: ;
        endcase

        // A download start overrides everything and restarts from a clean slate.
        if (dl_rise) begin
            state_d    = ST_LIT;
            addr_d     = BASE_ADDR;
            bw_d       = '0;
            ovf_d      = 1'b0;
            wr_d       = 1'b0;
            cnt_d      = '0;
            hold_d     = '0;
            rle_d      = RLE_EN ? rle_mode : 1'b0;
            fifo_pop   = 1'b0;
            fifo_flush = 1'b1;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_data      = data_q;
    assign mem_wr        = wr_q;
    assign loader_reset  = (state_q != ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign overflow      = ovf_q;
    assign bytes_written = bw_q;

endmodule

// File: doc/ace_snapshot_loader.md
ACE_SNAPSHOT_LOADER -- requirements
Module: ace_snapshot_loader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 16, target address width.
- BASE_ADDR, 16'h2000, address of the first output byte.
- FIFO_DEPTH, 8, input byte FIFO entries; power of two, at least 4.
- HOLD_CYCLES, 16, clk_sys cycles that loader_reset stays high after the stream ends.
- RLE_EN, 1, RLE decoder present; 0 means raw-only.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_sys, in, 1, the single clock.
- reset, in, 1, asynchronous active-high reset.
- ioctl_download, in, 1, download window.
- ioctl_wr, in, 1, byte strobe; one cycle per byte; no backpressure.
- ioctl_dout, in, 8, byte value.
- rle_mode, in, 1, sampled at download start: 1 = RLE stream, 0 = raw.
- mem_addr, out, ADDR_W, write address.
- mem_data, out, 8, write data.
- mem_wr, out, 1, write request.
- mem_ready, in, 1, memory accepts mem_wr this cycle.
- loader_reset, out, 1, holds the machine in reset.
- busy, out, 1, load in progress.
- overflow, out, 1, sticky error: FIFO overrun.
- bytes_written, out, ADDR_W, count of completed writes.

Function
REQ-003 The FIFO shall capture ioctl_dout on each cycle with ioctl_wr=1 and ioctl_download=1; a write while the FIFO is full shall drop the byte and set overflow.
- Simultaneous push and pop when full is legal; it is not an overflow.

REQ-004 Download start is a rising edge of ioctl_download; on it the block shall:
- set loader_reset=1 and busy=1;
- clear overflow and bytes_written;
- load the address to BASE_ADDR;
- latch rle_mode (forced to 0 when RLE_EN=0).

REQ-005 The decoder states shall be IDLE, LIT, ESC, CNT, RUN, DONE and HOLD.

REQ-006 Raw mode: each popped byte shall be one write.

REQ-007 RLE mode (LIT state):
- A byte other than 8'hED is a literal write.
- 8'hED moves to ESC.

REQ-008 ESC state: the next byte n is consumed.
- n=0 goes to DONE; remaining input is discarded until ioctl_download falls.
- n>=1 goes to CNT.

REQ-009 CNT state: the next byte v is consumed, then RUN issues exactly n writes of v.
- ED 01 ED therefore writes a single literal 8'hED.

REQ-010 Write handshake:
- mem_wr shall stay asserted with mem_addr and mem_data stable until a cycle with mem_ready=1.
- On that cycle the address and bytes_written shall increment.
- At most one write per cycle.
- The FIFO shall pop only when the decoder can consume.

REQ-011 Addresses shall wrap modulo 2^ADDR_W with no error.

REQ-012 End of stream:
- On a falling edge of ioctl_download, the block shall drain the FIFO, finish any RUN, then enter HOLD.
- An ESC or CNT sequence left incomplete is discarded.
- HOLD shall count HOLD_CYCLES, then deassert loader_reset and busy and return to IDLE.

REQ-013 A rising ioctl_download edge in any state shall restart per REQ-004 and flush the FIFO.

REQ-014 Latency: a popped literal shall produce mem_wr on the next cycle.

Reset
REQ-015 While reset is high, outputs shall be:
- mem_wr=0, loader_reset=0, busy=0, overflow=0;
- bytes_written=0, mem_addr=BASE_ADDR, mem_data=0;
- FIFO empty, state IDLE.

REQ-016 Reset asserted mid-load shall abort immediately; no further writes shall occur.

Structure
REQ-017 The shared package shall hold:
- the decoder state enum;
- localparam ACE_ESC=8'hED;
- the default BASE_ADDR.

REQ-018 The FIFO shall be the sub-module loader_fifo, parametrised by width 8 and FIFO_DEPTH, with push, pop, full, empty and level.

Verification
REQ-019 Raw mode, bytes 11 22 33, mem_ready=1 -> writes to 2000, 2001, 2002; bytes_written=3; loader_reset falls HOLD_CYCLES after the download ends.

REQ-020 RLE stream 41 ED 04 00 ED 01 ED ED 00 -> writes 41 at 2000, 00 at 2001-2004, ED at 2005; then DONE.

REQ-021 RLE stream ED FF AA with mem_ready toggling 50% -> 255 writes of AA, data stable while stalled, addr ends at 20FF.

REQ-022 Burst of FIFO_DEPTH+2 strobes with mem_ready=0 -> overflow=1; first FIFO_DEPTH bytes written after ready, 2 dropped.

REQ-023 Reset pulsed during RUN -> all outputs at reset values, no mem_wr afterwards; a new download restarts at 2000.

REQ-024 ADDR_W=16, BASE_ADDR=FFFE, 3 raw bytes -> addresses FFFE, FFFF, 0000.
